// File: rtl/axis_byte_packer_pkg.sv
// Shared types and helpers for the SERDES byte packer/unpacker.
// Entry layout: payload in the low byte, LAST and NULL flags above it.
package axis_byte_packer_pkg;

    localparam int DEF_BYTE_W = 8;
    localparam int LAST_BIT   = DEF_BYTE_W;
    localparam int NULL_BIT   = DEF_BYTE_W + 1;
    localparam int MAX_LANES  = 64;

    typedef struct packed {
        logic                  nul;
        logic                  last;
        logic [DEF_BYTE_W-1:0] data;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int lowest_set(input logic [MAX_LANES-1:0] mask);
        int r;
        r = 0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_byte_packer_if.sv
// AXI-Stream input and FIFO write port of the byte packer.
// The master side is the traffic source plus the FIFO model.
interface axis_byte_packer_if #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = axis_byte_packer_pkg::DEF_BYTE_W
);
    localparam int LANES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] s_axis_tdata;
    logic [LANES-1:0]  s_axis_tkeep;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              o_fifo_wr;
    logic [BYTE_W+1:0] o_fifo_wdata;
    logic              i_fifo_wfull;

    modport master (
        output s_axis_tdata,
        output s_axis_tkeep,
        output s_axis_tlast,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  o_fifo_wr,
        input  o_fifo_wdata,
        output i_fifo_wfull
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tkeep,
        input  s_axis_tlast,
        input  s_axis_tvalid,
        output s_axis_tready,
        output o_fifo_wr,
        output o_fifo_wdata,
        input  i_fifo_wfull
    );

endinterface

// File: rtl/axis_byte_packer_lane_picker.sv
// Remaining keep mask -> lowest set lane and whether it is the last one.
// Shared with the receive-side unpacker.
module axis_byte_packer_lane_picker
    import axis_byte_packer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] i_mask,
    output logic [LW-1:0]    o_lane,
    output logic             o_final
);

    assign o_lane  = LW'(lowest_set(MAX_LANES'(i_mask)));
    assign o_final = (i_mask != '0) &&
                     ((i_mask & (i_mask - LANES'(1))) == '0);

endmodule

// File: rtl/axis_byte_packer.sv
// Serialises wide AXIS beats into flagged byte entries for the CDC FIFO.
// The next FIFO entry is precomputed so o_fifo_wdata comes from a flop.
module axis_byte_packer
    import axis_byte_packer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic                i_wclk,
    input  logic                i_rst_n,
    axis_byte_packer_if.slave   bus,
    output logic [15:0]         o_pkt_count,
    output logic                o_busy
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LBIT  = LAST_BIT - DEF_BYTE_W + BYTE_W;
    localparam int NBIT  = NULL_BIT - DEF_BYTE_W + BYTE_W;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [LANES-1:0]  mask_q, mask_n;
    logic              last_q, last_n;
    logic              null_q, null_n;
    logic [BYTE_W+1:0] wdata_q, wdata_n;
    logic [15:0]       cnt_q;

    logic [LW-1:0] cur_lane, nxt_lane;
    logic          cur_final, nxt_final;
    logic          wr, fin, tready, accept, drop;

    axis_byte_packer_lane_picker #(.LANES(LANES), .LW(LW)) u_cur (
        .i_mask  (mask_q),
        .o_lane  (cur_lane),
        .o_final (cur_final)
    );

    axis_byte_packer_lane_picker #(.LANES(LANES), .LW(LW)) u_nxt (
        .i_mask  (mask_n),
        .o_lane  (nxt_lane),
        .o_final (nxt_final)
    );

    assign fin    = null_q | cur_final;
    assign wr     = (state_q == SHIFT) && !bus.i_fifo_wfull;
    assign tready = i_rst_n && ((state_q == IDLE) || (wr && fin));
    assign accept = bus.s_axis_tvalid && tready;
    assign drop   = (bus.s_axis_tkeep == '0) && !bus.s_axis_tlast;

    assign bus.s_axis_tready = tready;
    assign bus.o_fifo_wr     = wr;
    assign bus.o_fifo_wdata  = wdata_q;
    assign o_pkt_count       = cnt_q;
    assign o_busy            = (state_q == SHIFT);

    always_ff @(posedge i_wclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            null_q  <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            mask_q  <= mask_n;
            last_q  <= last_n;
            null_q  <= null_n;
            wdata_q <= wdata_n;
            if (wr && wdata_q[LBIT]) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        mask_n  = mask_q;
        last_n  = last_q;
        null_n  = null_q;
        if (accept) begin
            data_n  = bus.s_axis_tdata;
            mask_n  = bus.s_axis_tkeep;
            last_n  = bus.s_axis_tlast;
            null_n  = (bus.s_axis_tkeep == '0);
            state_n = drop ? IDLE : SHIFT;
        end else if (wr) begin
            mask_n = mask_q & ~(LANES'(1) << cur_lane);
            null_n = 1'b0;
            if (fin) state_n = IDLE;
        end
    end

    // Entry that will be on the write port next cycle.
    always_comb begin
        wdata_n = '0;
        if (state_n == SHIFT) begin
            if (null_n) begin
                wdata_n[LBIT] = 1'b1;
                wdata_n[NBIT] = 1'b1;
            end else begin
                wdata_n[BYTE_W-1:0] = data_n[int'(nxt_lane)*BYTE_W +: BYTE_W];
                wdata_n[LBIT]       = last_n && nxt_final;
            end
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer: framing, backpressure, nulls,
// async reset and packet counter wrap.
module tb_axis_byte_packer;

    logic        clk;
    logic        rst_n;
    logic [15:0] pkt;
    logic        busy;
    int          vec;
    int          errs;
    int          cyc;
    int          rdy_busy;
    logic [9:0]  wq[$];
    int          wc[$];

    axis_byte_packer_if #(.DATA_W(32), .BYTE_W(8)) bus ();

    axis_byte_packer #(.DATA_W(32), .BYTE_W(8)) dut (
        .i_wclk      (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_pkt_count (pkt),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_fifo_wr) begin
            wq.push_back(bus.o_fifo_wdata);
            wc.push_back(cyc);
        end
        if (bus.s_axis_tready && busy) rdy_busy <= rdy_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k,
                        input logic l);
        bit ok;
        ok = 1'b0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_axis_tready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clearq();
        wq.delete();
        wc.delete();
    endtask

    task automatic chk_q(input string tag, input int idx,
                         input logic [9:0] exp);
        if (idx < wq.size()) chk(tag, 32'(wq[idx]), 32'(exp));
        else chk(tag, 32'hDEAD, 32'(exp));
    endtask

    initial begin
        bit hit;
        vec  = 0;
        errs = 0;
        cyc  = 0;
        rdy_busy = 0;
        rst_n = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.i_fifo_wfull  = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("rst_wr", 32'(bus.o_fifo_wr), 32'd0);
        chk("rst_wdata", 32'(bus.o_fifo_wdata), 32'd0);
        chk("rst_pkt", 32'(pkt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk);
        #1;

        // full beat, one-cycle latency
        clearq();
        send(32'h44332211, 4'hF, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("lat_wr", 32'(bus.o_fifo_wr), 32'd1);
        chk("lat_wdata", 32'(bus.o_fifo_wdata), 32'h011);
        wait_idle();
        chk("full_n", 32'(wq.size()), 32'd4);
        chk_q("full_0", 0, 10'h011);
        chk_q("full_1", 1, 10'h022);
        chk_q("full_2", 2, 10'h033);
        chk_q("full_3", 3, 10'h144);
        if (wc.size() == 4) chk("full_gap", 32'(wc[3] - wc[0]), 32'd3);
        chk("full_pkt", 32'(pkt), 32'd1);

        // sparse keep
        clearq();
        send(32'hDDCCBBAA, 4'b1010, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        wait_idle();
        chk("sparse_n", 32'(wq.size()), 32'd2);
        chk_q("sparse_0", 0, 10'h0BB);
        chk_q("sparse_1", 1, 10'h1DD);
        chk("sparse_pkt", 32'(pkt), 32'd2);

        // back-to-back beats
        clearq();
        rdy_busy = 0;
        send(32'h14131211, 4'hF, 1'b0);
        send(32'h24232221, 4'hF, 1'b0);
        send(32'h34333231, 4'hF, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        wait_idle();
        chk("b2b_n", 32'(wq.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            logic [9:0] e;
            e = {1'b0, (i == 11), 8'(8'h11 + (i / 4) * 16 + (i % 4))};
            chk_q($sformatf("b2b_%0d", i), i, e);
        end
        if (wc.size() == 12) chk("b2b_gap", 32'(wc[11] - wc[0]), 32'd11);
        chk("b2b_tready", 32'(rdy_busy), 32'd3);
        chk("b2b_pkt", 32'(pkt), 32'd3);

        // backpressure after two bytes
        clearq();
        send(32'h88776655, 4'hF, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i_fifo_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_wr_%0d", i), 32'(bus.o_fifo_wr), 32'd0);
            chk($sformatf("bp_dat_%0d", i), 32'(bus.o_fifo_wdata), 32'h077);
            chk($sformatf("bp_rdy_%0d", i), 32'(bus.s_axis_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.i_fifo_wfull = 1'b0;
        wait_idle();
        chk("bp_n", 32'(wq.size()), 32'd4);
        chk_q("bp_0", 0, 10'h055);
        chk_q("bp_1", 1, 10'h066);
        chk_q("bp_2", 2, 10'h077);
        chk_q("bp_3", 3, 10'h188);
        chk("bp_pkt", 32'(pkt), 32'd4);

        // null beats
        clearq();
        send(32'h12345678, 4'h0, 1'b0);
        bus.s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drop_n", 32'(wq.size()), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_pkt", 32'(pkt), 32'd4);
        send(32'h0, 4'h0, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        wait_idle();
        chk("null_n", 32'(wq.size()), 32'd1);
        chk_q("null_0", 0, 10'h300);
        chk("null_pkt", 32'(pkt), 32'd5);

        // async reset mid-beat
        clearq();
        send(32'h99887766, 4'hF, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_wr", 32'(bus.o_fifo_wr), 32'd0);
        chk("mrst_wdata", 32'(bus.o_fifo_wdata), 32'd0);
        chk("mrst_pkt", 32'(pkt), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_tready", 32'(bus.s_axis_tready), 32'd0);
        chk("mrst_n", 32'(wq.size()), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearq();
        send(32'h44332211, 4'hF, 1'b1);
        bus.s_axis_tvalid = 1'b0;
        wait_idle();
        chk("rec_n", 32'(wq.size()), 32'd4);
        chk_q("rec_0", 0, 10'h011);
        chk_q("rec_3", 3, 10'h144);
        chk("rec_pkt", 32'(pkt), 32'd1);

        // counter wrap with back-to-back null packets
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = 4'h0;
        bus.s_axis_tlast  = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 70000 && !hit; i++) begin
            @(negedge clk);
            wq.delete();
            wc.delete();
            hit = (pkt == 16'hFFFF);
        end
        bus.s_axis_tvalid = 1'b0;
        chk("wrap_reach", 32'(hit), 32'd1);
        chk("wrap_pending", 32'(bus.o_fifo_wr), 32'd1);
        wait_idle();
        chk("wrap_pkt", 32'(pkt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
